// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are
// available, snoops the CDB for wakeup, and issues one ready op per cycle.
module alu_rs #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4,
  parameter int OP_W  = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             dis_valid,
  input  logic [OP_W-1:0]  dis_op,
  input  logic [31:0]      dis_vj,
  input  logic [31:0]      dis_vk,
  input  logic             dis_qj_busy,
  input  logic             dis_qk_busy,
  input  logic [TAG_W-1:0] dis_qj,
  input  logic [TAG_W-1:0] dis_qk,
  input  logic [TAG_W-1:0] dis_rob,
  output logic             full,
  output logic             empty,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_rob,
  input  logic [31:0]      cdb_val,
  output logic             alu_status,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_rs1,
  output logic [31:0]      alu_rs2,
  output logic [TAG_W-1:0] alu_rob
);

  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] busy_q, busy_d, qjb_q, qjb_d, qkb_q, qkb_d;
  logic [OP_W-1:0]  op_q  [DEPTH];
  logic [OP_W-1:0]  op_d  [DEPTH];
  logic [31:0]      vj_q  [DEPTH];
  logic [31:0]      vj_d  [DEPTH];
  logic [31:0]      vk_q  [DEPTH];
  logic [31:0]      vk_d  [DEPTH];
  logic [TAG_W-1:0] qj_q  [DEPTH];
  logic [TAG_W-1:0] qj_d  [DEPTH];
  logic [TAG_W-1:0] qk_q  [DEPTH];
  logic [TAG_W-1:0] qk_d  [DEPTH];
  logic [TAG_W-1:0] rob_q [DEPTH];
  logic [TAG_W-1:0] rob_d [DEPTH];

  logic             status_q, status_d;
  logic [OP_W-1:0]  aop_q, aop_d;
  logic [31:0]      ars1_q, ars1_d, ars2_q, ars2_d;
  logic [TAG_W-1:0] arob_q, arob_d;

  logic [DEPTH-1:0] ready_s, wake_j_s, wake_k_s;
  logic             iss_hit_s, free_hit_s, byp_j_s, byp_k_s;
  logic [IW-1:0]    iss_idx_s, free_idx_s;

  // Ready/free priority pick (lowest index wins), CDB match vectors, status flags
  always_comb begin
    ready_s    = busy_q & ~qjb_q & ~qkb_q;
    iss_hit_s  = |ready_s;
    free_hit_s = ~&busy_q;
    iss_idx_s  = '0;
    free_idx_s = '0;
    wake_j_s   = '0;
    wake_k_s   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      iss_idx_s   = ready_s[i] ? IW'(i) : iss_idx_s;
      free_idx_s  = busy_q[i] ? free_idx_s : IW'(i);
      wake_j_s[i] = cdb_valid & busy_q[i] & qjb_q[i] & (qj_q[i] == cdb_rob);
      wake_k_s[i] = cdb_valid & busy_q[i] & qkb_q[i] & (qk_q[i] == cdb_rob);
    end
    byp_j_s = cdb_valid & dis_qj_busy & (dis_qj == cdb_rob);
    byp_k_s = cdb_valid & dis_qk_busy & (dis_qk == cdb_rob);
    full    = &busy_q;
    empty   = ~|busy_q;
  end

  // Next-state: clear beats freeze beats normal wakeup/issue/dispatch
  always_comb begin
    busy_d   = busy_q;
    qjb_d    = qjb_q;
    qkb_d    = qkb_q;
    op_d     = op_q;
    vj_d     = vj_q;
    vk_d     = vk_q;
    qj_d     = qj_q;
    qk_d     = qk_q;
    rob_d    = rob_q;
    status_d = 1'b0;
    aop_d    = aop_q;
    ars1_d   = ars1_q;
    ars2_d   = ars2_q;
    arob_d   = arob_q;
    if (clear) begin
      busy_d = '0;
    end else if (!rdy_in) begin
      status_d = 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        vj_d[i] = wake_j_s[i] ? cdb_val : vj_q[i];
        vk_d[i] = wake_k_s[i] ? cdb_val : vk_q[i];
      end
      qjb_d = qjb_q & ~wake_j_s;
      qkb_d = qkb_q & ~wake_k_s;
      if (iss_hit_s) begin
        status_d          = 1'b1;
        aop_d             = op_q[iss_idx_s];
        ars1_d            = vj_q[iss_idx_s];
        ars2_d            = vk_q[iss_idx_s];
        arob_d            = rob_q[iss_idx_s];
        busy_d[iss_idx_s] = 1'b0;
      end else begin
        status_d = 1'b0;
      end
      // Free slot is chosen on pre-edge busy, so it can never be the issuing slot
      if (dis_valid && free_hit_s) begin
        busy_d[free_idx_s] = 1'b1;
        op_d[free_idx_s]   = dis_op;
        rob_d[free_idx_s]  = dis_rob;
        qj_d[free_idx_s]   = dis_qj;
        qk_d[free_idx_s]   = dis_qk;
        qjb_d[free_idx_s]  = dis_qj_busy & ~byp_j_s;
        qkb_d[free_idx_s]  = dis_qk_busy & ~byp_k_s;
        vj_d[free_idx_s]   = byp_j_s ? cdb_val : dis_vj;
        vk_d[free_idx_s]   = byp_k_s ? cdb_val : dis_vk;
      end else begin
        busy_d[free_idx_s] = busy_d[free_idx_s];
      end
    end
  end

  // Control and issue payload registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy_q   <= '0;
      qjb_q    <= '0;
      qkb_q    <= '0;
      status_q <= 1'b0;
      aop_q    <= '0;
      ars1_q   <= 32'd0;
      ars2_q   <= 32'd0;
      arob_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      qjb_q    <= qjb_d;
      qkb_q    <= qkb_d;
      status_q <= status_d;
      aop_q    <= aop_d;
      ars1_q   <= ars1_d;
      ars2_q   <= ars2_d;
      arob_q   <= arob_d;
    end
  end

  // Entry payload storage; only meaningful while the busy bit is set
  always_ff @(posedge clk_in) begin
    op_q  <= op_d;
    vj_q  <= vj_d;
    vk_q  <= vk_d;
    qj_q  <= qj_d;
    qk_q  <= qk_d;
    rob_q <= rob_d;
  end

  assign alu_status = status_q;
  assign alu_op     = aop_q;
  assign alu_rs1    = ars1_q;
  assign alu_rs2    = ars2_q;
  assign alu_rob    = arob_q;

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: a slot-level reference model predicts issues
// into a queue; a negedge monitor pops and compares against DUT outputs.
module tb_alu_rs;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, dis_valid, dis_qj_busy, dis_qk_busy, cdb_valid;
  logic [5:0]  dis_op;
  logic [31:0] dis_vj, dis_vk, cdb_val;
  logic [3:0]  dis_qj, dis_qk, dis_rob, cdb_rob;
  logic        full, empty, alu_status;
  logic [5:0]  alu_op;
  logic [31:0] alu_rs1, alu_rs2;
  logic [3:0]  alu_rob;

  alu_rs dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .dis_valid(dis_valid), .dis_op(dis_op), .dis_vj(dis_vj), .dis_vk(dis_vk),
    .dis_qj_busy(dis_qj_busy), .dis_qk_busy(dis_qk_busy), .dis_qj(dis_qj),
    .dis_qk(dis_qk), .dis_rob(dis_rob), .full(full), .empty(empty),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_val(cdb_val),
    .alu_status(alu_status), .alu_op(alu_op), .alu_rs1(alu_rs1),
    .alu_rs2(alu_rs2), .alu_rob(alu_rob)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit busy; bit [5:0] op; bit [31:0] vj, vk; bit jb, kb; bit [3:0] qj, qk, rob;
  } ent_t;
  ent_t m[8];
  ent_t nx[8];
  logic [73:0] expq[$];
  logic [73:0] exp_last = 74'd0;
  logic [73:0] got;
  int   n_tests = 0, n_fail = 0, iss, fr, cnt;
  bit   started = 1'b0;

  // Reference model: one step per clock edge, from the station's stated rules
  always @(posedge clk_in) begin
    started = 1'b1;
    if (!rst_in) begin
      for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
      exp_last = 74'd0;
    end else if (clear) begin
      for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
    end else if (rdy_in) begin
      iss = -1; fr = -1;
      for (int i = 0; i < 8; i++) begin
        if (iss < 0 && m[i].busy && !m[i].jb && !m[i].kb) iss = i;
        if (fr < 0 && !m[i].busy) fr = i;
      end
      nx = m;
      for (int i = 0; i < 8; i++) begin
        if (cdb_valid && nx[i].busy && nx[i].jb && nx[i].qj == cdb_rob) begin
          nx[i].vj = cdb_val; nx[i].jb = 1'b0;
        end
        if (cdb_valid && nx[i].busy && nx[i].kb && nx[i].qk == cdb_rob) begin
          nx[i].vk = cdb_val; nx[i].kb = 1'b0;
        end
      end
      if (iss >= 0) begin
        exp_last = {m[iss].op, m[iss].vj, m[iss].vk, m[iss].rob};
        expq.push_back(exp_last);
        nx[iss].busy = 1'b0;
      end
      if (dis_valid && fr >= 0) begin
        nx[fr].busy = 1'b1; nx[fr].op = dis_op; nx[fr].rob = dis_rob;
        nx[fr].qj = dis_qj; nx[fr].qk = dis_qk;
        nx[fr].jb = dis_qj_busy; nx[fr].kb = dis_qk_busy;
        nx[fr].vj = dis_vj; nx[fr].vk = dis_vk;
        if (cdb_valid && dis_qj_busy && dis_qj == cdb_rob) begin
          nx[fr].jb = 1'b0; nx[fr].vj = cdb_val;
        end
        if (cdb_valid && dis_qk_busy && dis_qk == cdb_rob) begin
          nx[fr].kb = 1'b0; nx[fr].vk = cdb_val;
        end
      end
      m = nx;
    end
  end

  // Monitor: pop on every presented issue, otherwise check payload hold
  always @(negedge clk_in) begin
    if (started) begin
      got = {alu_op, alu_rs1, alu_rs2, alu_rob};
      n_tests++;
      if (alu_status !== (expq.size() != 0)) begin
        n_fail++;
        $display("FAIL status t=%0t: got %b expected %b", $time, alu_status, expq.size() != 0);
      end
      n_tests++;
      if (expq.size() != 0) begin
        if (got !== expq[0]) begin
          n_fail++;
          $display("FAIL issue_payload t=%0t: got %h expected %h", $time, got, expq[0]);
        end
        void'(expq.pop_front());
      end else if (got !== exp_last) begin
        n_fail++;
        $display("FAIL hold_payload t=%0t: got %h expected %h", $time, got, exp_last);
      end
      cnt = 0;
      for (int i = 0; i < 8; i++) cnt += m[i].busy ? 1 : 0;
      n_tests++;
      if (full !== (cnt == 8) || empty !== (cnt == 0)) begin
        n_fail++;
        $display("FAIL full_empty t=%0t: got %b%b expected %b%b", $time, full, empty, cnt == 8, cnt == 0);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic quiet();
    dis_valid = 1'b0; cdb_valid = 1'b0; clear = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] vj, vk,
                      input logic jb, input logic [3:0] qj,
                      input logic kb, input logic [3:0] qk, input logic [3:0] rob);
    dis_valid = 1'b1; dis_op = op; dis_vj = vj; dis_vk = vk;
    dis_qj_busy = jb; dis_qj = qj; dis_qk_busy = kb; dis_qk = qk; dis_rob = rob;
    tick();
    dis_valid = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_rob = tag; cdb_val = val;
    tick();
    cdb_valid = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; quiet();
    dis_op = 6'd0; dis_vj = 32'd0; dis_vk = 32'd0; dis_qj_busy = 1'b0; dis_qk_busy = 1'b0;
    dis_qj = 4'd0; dis_qk = 4'd0; dis_rob = 4'd0; cdb_rob = 4'd0; cdb_val = 32'd0;
    tick(2);
    rst_in = 1'b1;
    tick();
    // Basic ready dispatch, then pending-operand wakeup
    disp(6'd1, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    tick(2);
    disp(6'd2, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4);
    tick(2);
    cdb(4'd2, 32'h10);
    tick(2);
    // Dispatch-time bypass from the CDB
    cdb_valid = 1'b1; cdb_rob = 4'd6; cdb_val = 32'd9;
    disp(6'd3, 32'd0, 32'd2, 1'b1, 4'd6, 1'b0, 4'd0, 4'd5);
    cdb_valid = 1'b0;
    tick(2);
    // Fill all slots, drop a ninth, wake slot 5
    for (int i = 0; i < 8; i++)
      disp(6'(i), 32'(i), 32'(i + 100), 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(i));
    disp(6'd63, 32'd1, 32'd1, 1'b1, 4'd13, 1'b0, 4'd0, 4'd15);
    cdb(4'd13, 32'hABCD);
    tick(2);
    // Clear discards pending entries; later CDB wakes nothing
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 4; i++) disp(6'd4, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1, 4'(i), 4'(i));
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 4; i++) cdb(4'(i), 32'h55);
    tick(2);
    // Freeze with ready entries, then release
    for (int i = 0; i < 3; i++) disp(6'(10 + i), 32'(i), 32'(i), 1'b1, 4'd7, 1'b1, 4'd7, 4'(i));
    cdb_valid = 1'b1; cdb_rob = 4'd7; cdb_val = 32'h77; rdy_in = 1'b1;
    tick(); cdb_valid = 1'b0;
    rdy_in = 1'b0; tick(3); rdy_in = 1'b1;
    tick(4);
    // Mid-operation reset
    disp(6'd5, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    rst_in = 1'b0; tick(); rst_in = 1'b1; tick(2);
    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      dis_valid = 1'($urandom_range(0, 1)); dis_op = 6'($urandom);
      dis_vj = $urandom; dis_vk = $urandom;
      dis_qj_busy = 1'($urandom_range(0, 1)); dis_qk_busy = 1'($urandom_range(0, 1));
      dis_qj = 4'($urandom); dis_qk = 4'($urandom); dis_rob = 4'($urandom);
      cdb_valid = ($urandom_range(0, 2) != 0); cdb_rob = 4'($urandom); cdb_val = $urandom;
      clear = ($urandom_range(0, 79) == 0);
      rdy_in = ($urandom_range(0, 7) != 0);
      rst_in = ($urandom_range(0, 299) != 0);
      tick();
    end
    quiet(); rst_in = 1'b1;
    tick(3);
    @(negedge clk_in); #1;
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected: got %0d pending expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter DEPTH, default 8, number of reservation-station entries (power of two, >=2).
REQ-002 Parameter TAG_W, default 4, ROB tag width.
REQ-003 Parameter OP_W, default 6, opcode width.
REQ-004 clk_in  input  1  single clock; all state updates on rising edge.
REQ-005 rst_in  input  1  reset, synchronous, active-low.
REQ-006 rdy_in  input  1  global enable; low = freeze all state.
REQ-007 clear  input  1  flush (branch mispredict).
REQ-008 dis_valid  input  1  dispatch request this cycle.
REQ-009 dis_op  input  OP_W  opcode.
REQ-010 dis_vj, dis_vk  input  32 each  operand values, meaningful when the matching busy bit is 0.
REQ-011 dis_qj_busy, dis_qk_busy  input  1 each  operand pending.
REQ-012 dis_qj, dis_qk  input  TAG_W each  producer ROB tag of pending operand.
REQ-013 dis_rob  input  TAG_W  destination ROB tag.
REQ-014 full  output  1  combinational; all DEPTH entries busy.
REQ-015 empty  output  1  combinational; no entry busy.
REQ-016 cdb_valid  input  1  result broadcast valid (ALU to_ROB_Status).
REQ-017 cdb_rob, cdb_val  input  TAG_W, 32  broadcast tag and value.
REQ-018 alu_status  output  1  registered; issue strobe to ALU.
REQ-019 alu_op, alu_rs1, alu_rs2, alu_rob  output  OP_W, 32, 32, TAG_W  registered issue payload.

Function
REQ-020 Entry state SHALL be: busy, op, vj, vk, qj_busy, qj, qk_busy, qk, rob.
REQ-021 Priority SHALL be: rst_in low > clear > rdy_in low > normal operation.
REQ-022 Dispatch: when dis_valid=1 and full=0 at an edge, the lowest-index non-busy entry (pre-edge state) SHALL be written and set busy; dis_valid with full=1 SHALL be ignored.
REQ-023 Dispatch bypass: if cdb_valid=1 and cdb_rob equals a pending dis_qj (dis_qk), the entry SHALL store cdb_val with qj_busy=0 (qk_busy=0).
REQ-024 Wakeup: every busy entry with qj_busy=1 and qj==cdb_rob under cdb_valid SHALL capture vj=cdb_val, qj_busy=0; likewise k; j and k may wake in the same cycle.
REQ-025 Ready = busy & ~qj_busy & ~qk_busy, evaluated on pre-edge state; an entry woken at edge N is issuable no earlier than edge N+1.
REQ-026 Issue: at each normal edge, the lowest-index ready entry SHALL be copied to alu_op/alu_rs1(vj)/alu_rs2(vk)/alu_rob, alu_status set 1, and the entry cleared busy at that same edge.
REQ-027 With no ready entry, alu_status SHALL be 0 after the edge; payload registers hold.
REQ-028 At most one issue and one dispatch per edge; both may occur at the same edge; a slot freed by issue SHALL NOT accept the same-edge dispatch.
REQ-029 Latency: dispatch with both operands ready at edge N -> alu_status=1 in the cycle after edge N+1 (empty RS).
REQ-030 clear=1 at an edge SHALL clear all busy bits and set alu_status=0; dispatch and CDB that edge are ignored.
REQ-031 rdy_in=0 at an edge SHALL hold every entry and payload register and set alu_status=0; no dispatch, wakeup or issue occurs (upstream holds CDB).
REQ-032 Tag comparisons SHALL be full TAG_W equality; tag 0 is a legal tag.

Reset
REQ-033 rst_in low at an edge SHALL clear all busy bits, alu_status=0, alu_op/alu_rs1/alu_rs2/alu_rob=0; full=0, empty=1 thereafter.
REQ-034 Reset mid-operation SHALL discard all entries with no issue in the following cycle.

Verification
REQ-035 Dispatch op=ADD, vj=5, vk=7, both ready, rob=3 -> one cycle later alu_status=1, alu_rs1=5, alu_rs2=7, alu_rob=3, for exactly one cycle; empty=1 after.
REQ-036 Dispatch qj_busy=1 qj=2, vk=1; two idle cycles (alu_status=0); cdb_valid rob=2 val=0x10 -> next edge alu_status=1, alu_rs1=0x10.
REQ-037 Dispatch with qj=6 while cdb_valid rob=6 val=9 same cycle -> entry ready, issues next edge with alu_rs1=9.
REQ-038 Dispatch 8 non-ready entries -> full=1; 9th dispatch dropped; wake entry 5 -> issues, full=0 after.
REQ-039 Fill 4 entries, assert clear -> alu_status=0, empty=1, subsequent CDB produces no issue.
REQ-040 Hold rdy_in=0 with ready entries for 3 cycles -> alu_status=0, entries retained; rdy_in=1 -> lowest-index issues first.
